display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arb_pkg.sv | 23 ++
 rtl/display_arbiter_rr_pick.sv | 30 +++
 rtl/display_arbiter.sv | 109 ++++++++++
 tb/tb_display_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_arb_pkg.sv
// Shared constants, state encoding and helpers for the display arbiter.
// The optional preemption feature is selected with DISPLAY_ARB_PREEMPT_EN (see display_arbiter.sv).
package display_arb_pkg;

   localparam int N_REQ = 4;
   localparam int REQ_W = 32;
   localparam int IDX_W = 2;

   localparam logic [REQ_W-1:0] IDLE_DATA_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request searching upward from
// last_owner+1 with wrap, so the previous owner is considered last.
module rr_pick
   import display_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_owner_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      cand  = '0;
      idx_o = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = last_owner_i + IDX_W'(k + 1);
         if (!found && req_i[cand]) begin
            idx_o = cand;
            found = 1'b1;
         end
      end
   end

   assign valid_o = found;

endmodule

// File: rtl/display_arbiter.sv
// Four-way round-robin owner of an 8-digit hex display with a minimum dwell per grant.
// Define DISPLAY_ARB_PREEMPT_EN to let requester 0 preempt any other owner immediately.
module display_arbiter
   import display_arb_pkg::*;
#(
   parameter int               DWELL     = 50_000_000,
   parameter logic [REQ_W-1:0] IDLE_DATA = IDLE_DATA_DEFAULT
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*REQ_W-1:0] req_data_i,
   output logic [REQ_W-1:0]       disp_data_o,
   output logic [N_REQ-1:0]       grant_o,
   output logic                   switched_o,
   output state_t                 state_o
);

   localparam int               CNT_W  = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

   state_t           state_q;
   logic [N_REQ-1:0] grant_q;
   logic [REQ_W-1:0] disp_q;
   logic             switched_q;
   logic [CNT_W-1:0] dwell_cnt_q;
   logic [IDX_W-1:0] last_owner_q;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             preempt;
   logic             take;
   logic [IDX_W-1:0] take_idx;
   logic [REQ_W-1:0] owner_slice;
   logic [REQ_W-1:0] take_slice;

   // The current owner is masked out so that, once dwell expires, any other
   // requester wins; in IDLE grant_q is zero and the mask is a no-op.
   rr_pick u_rr_pick (
      .req_i        (req_i & ~grant_q),
      .last_owner_i (last_owner_q),
      .valid_o      (pick_valid),
      .idx_o        (pick_idx)
   );

`ifdef DISPLAY_ARB_PREEMPT_EN
   assign preempt = (state_q == OWN) && req_i[0] && (last_owner_q != '0);
`else
   assign preempt = 1'b0;
`endif

   assign take     = preempt || (pick_valid && ((state_q == IDLE) || (dwell_cnt_q == '0)));
   assign take_idx = preempt ? '0 : pick_idx;

   // last_owner_q always names the owner while in OWN.
   assign owner_slice = req_data_i[{last_owner_q, 5'd0} +: REQ_W];
   assign take_slice  = req_data_i[{take_idx, 5'd0} +: REQ_W];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         disp_q       <= IDLE_DATA;
         switched_q   <= 1'b0;
         dwell_cnt_q  <= '0;
         last_owner_q <= IDX_W'(N_REQ - 1);
      end else begin
         switched_q <= 1'b0;
         if (take) begin
            state_q      <= OWN;
            grant_q      <= onehot(take_idx);
            disp_q       <= take_slice;
            switched_q   <= 1'b1;
            dwell_cnt_q  <= RELOAD;
            last_owner_q <= take_idx;
         end else begin
            case (state_q)
               IDLE: begin
                  grant_q <= '0;
                  disp_q  <= IDLE_DATA;
               end
               OWN: begin
                  if (dwell_cnt_q != '0) begin
                     dwell_cnt_q <= dwell_cnt_q - 1'b1;
                     disp_q      <= owner_slice;
                  end else if (req_i[last_owner_q]) begin
                     disp_q <= owner_slice;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                     disp_q  <= IDLE_DATA;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  disp_q  <= IDLE_DATA;
               end
            endcase
         end
      end
   end

   assign disp_data_o = disp_q;
   assign grant_o     = grant_q;
   assign switched_o  = switched_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: a DWELL=4 instance and a DWELL=1 instance share
// stimulus and are checked against an owner/remaining-dwell reference model.
module tb_display_arbiter;
   import display_arb_pkg::*;

   localparam int NI = 2;
   localparam int DW [NI] = '{4, 1};
   localparam logic [31:0] IDLE_V = 32'h0000_0000;

   logic          clk;
   logic          rst;
   logic [3:0]    req;
   logic [127:0]  req_data;
   logic [31:0]   disp_w     [NI];
   logic [3:0]    grant_w    [NI];
   logic          switched_w [NI];
   state_t        state_w    [NI];

   int checks   = 0;
   int failures = 0;

   // expected {grant, switched, disp} per instance per cycle
   logic [36:0] exp_q[$];

   // reference model state: owner index or -1, cycles of dwell still owed
   int m_owner [NI];
   int m_rem   [NI];
   int m_last  [NI];

   display_arbiter #(.DWELL(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
      .disp_data_o(disp_w[0]), .grant_o(grant_w[0]),
      .switched_o(switched_w[0]), .state_o(state_w[0])
   );

   display_arbiter #(.DWELL(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
      .disp_data_o(disp_w[1]), .grant_o(grant_w[1]),
      .switched_o(switched_w[1]), .state_o(state_w[1])
   );

   // clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int rr(input logic [3:0] r, input int last, input int excl);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (last + k) % 4;
         if (r[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < NI; u++) begin
         m_owner[u] = -1;
         m_rem[u]   = 0;
         m_last[u]  = 3;
      end
   endtask

   task automatic model_step(input int u, input logic [3:0] r, input logic [127:0] d);
      int nw;
      logic sw;
      logic [3:0] g;
      logic [31:0] dd;
      nw = -1;
`ifdef DISPLAY_ARB_PREEMPT_EN
      if (m_owner[u] > 0 && r[0]) nw = 0;
`endif
      if (nw < 0) begin
         if (m_owner[u] < 0) nw = rr(r, m_last[u], -1);
         else if (m_rem[u] == 0) nw = rr(r, m_last[u], m_owner[u]);
      end
      sw = 1'b0;
      if (nw >= 0) begin
         m_owner[u] = nw;
         m_rem[u]   = DW[u] - 1;
         m_last[u]  = nw;
         sw         = 1'b1;
      end else if (m_owner[u] >= 0) begin
         if (m_rem[u] > 0) m_rem[u]--;
         else if (!r[m_owner[u]]) m_owner[u] = -1;
      end
      g  = (m_owner[u] < 0) ? 4'b0000 : 4'(1 << m_owner[u]);
      dd = (m_owner[u] < 0) ? IDLE_V : d[m_owner[u]*32 +: 32];
      exp_q.push_back({g, sw, dd});
   endtask

   task automatic compare_all();
      for (int u = 0; u < NI; u++) begin
         logic [36:0] e;
         e = exp_q.pop_front();
         check($sformatf("grant_d%0d", DW[u]),    32'(grant_w[u]),    32'(e[36:33]));
         check($sformatf("switched_d%0d", DW[u]), 32'(switched_w[u]), 32'(e[32]));
         check($sformatf("disp_d%0d", DW[u]),     disp_w[u],          e[31:0]);
      end
   endtask

   // driver: called at a negedge, returns at the next negedge
   task automatic cycle(input logic [3:0] r, input logic [127:0] d);
      req      = r;
      req_data = d;
      @(posedge clk);
      for (int u = 0; u < NI; u++) model_step(u, r, d);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      for (int u = 0; u < NI; u++) begin
         check({tag, "_grant"}, 32'(grant_w[u]), 32'h0);
         check({tag, "_disp"}, disp_w[u], IDLE_V);
         check({tag, "_switched"}, 32'(switched_w[u]), 32'h0);
         check({tag, "_state"}, 32'(state_w[u]), 32'(IDLE));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [127:0] rnd_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      logic [127:0] d;
      rst      = 1'b1;
      req      = 4'b0000;
      req_data = '0;
      model_reset();
      #1;
      check_reset_values("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // idle with no requests
      for (int i = 0; i < 20; i++) cycle(4'b0000, rnd_data());

      // single requester 0, then a live payload change
      d = rnd_data();
      d[31:0] = 32'hDEAD_BEEF;
      cycle(4'b0001, d);
      check("first_grant", 32'(grant_w[0]), 32'h1);
      check("first_disp", disp_w[0], 32'hDEAD_BEEF);
      check("first_pulse", 32'(switched_w[0]), 32'h1);
      d[31:0] = 32'h1234_5678;
      cycle(4'b0001, d);
      check("live_disp", disp_w[0], 32'h1234_5678);
      check("pulse_once", 32'(switched_w[0]), 32'h0);

      // all requesting: rotate 0,1,2,3,0 holding each for DWELL=4 cycles
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle(4'b1111, rnd_data());
         check("rr_seq", 32'(grant_w[0]), 32'(1 << ((i / 4) % 4)));
         check("rr_pulse", 32'(switched_w[0]), 32'((i % 4) == 0));
      end

      // owner 1 drops its request during dwell
      do_reset();
      cycle(4'b0010, rnd_data());
      check("drop_grant", 32'(grant_w[0]), 32'h2);
      for (int i = 0; i < 6; i++) begin
         cycle(4'b0000, rnd_data());
         check("drop_hold", 32'(grant_w[0]), (i < 3) ? 32'h2 : 32'h0);
         check("drop_nopulse", 32'(switched_w[0]), 32'h0);
      end
      check("drop_disp", disp_w[0], IDLE_V);

      // requester 0 rises while requester 2 owns with two dwell cycles left
      do_reset();
      cycle(4'b0100, rnd_data());
      cycle(4'b0100, rnd_data());
      cycle(4'b0101, rnd_data());
`ifdef DISPLAY_ARB_PREEMPT_EN
      check("preempt_grant", 32'(grant_w[0]), 32'h1);
      check("preempt_pulse", 32'(switched_w[0]), 32'h1);
`else
      check("nopreempt_grant", 32'(grant_w[0]), 32'h4);
      check("nopreempt_pulse", 32'(switched_w[0]), 32'h0);
`endif
      for (int i = 0; i < 4; i++) cycle(4'b0101, rnd_data());

      // randomized traffic with occasional held requests
      begin
         logic [3:0] r;
         r = 4'b0000;
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(r, rnd_data());
         end
      end

      // asynchronous reset between edges, mid-dwell
      do_reset();
      cycle(4'b1111, rnd_data());
      cycle(4'b1111, rnd_data());
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_values("async");
      @(negedge clk);
      rst = 1'b0;
      cycle(4'b1010, rnd_data());
      check("restart_grant", 32'(grant_w[0]), 32'h2);
      check("restart_grant_d1", 32'(grant_w[1]), 32'h2);
      for (int i = 0; i < 10; i++) cycle(4'b1010, rnd_data());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
